// File: rtl/systolic_mac_array.sv
// N x N output-stationary systolic matrix engine over four semirings.
// Operands stream one A column / B row per beat; C drains one row per beat.
module systolic_mac_array #(
   parameter int N     = 4,
   parameter int W     = 4,
   parameter int ACC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N*W-1:0]     in_a,
   input  logic [N*W-1:0]     in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*ACC_W-1:0] out_data,
   output logic               out_last,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      FLUSH,
      DRAIN
   } state_t;

   localparam int FW = $clog2(2 * N);
   localparam int RW = $clog2(N);

   state_t          state;
   logic [1:0]      mode_q;
   logic [FW-1:0]   flush_cnt;
   logic [RW-1:0]   row;
   logic [RW-1:0]   row_sel;
   logic [N*ACC_W-1:0] row_data;
   logic            take;

   logic [W-1:0]     a_dl   [N][N-1];
   logic [W-1:0]     b_dl   [N][N-1];
   logic             v_dl   [N-1];
   logic [W-1:0]     a_reg  [N][N-1];
   logic             t_reg  [N][N-1];
   logic [W-1:0]     b_reg  [N-1][N];
   logic [W-1:0]     a_pipe [N][N];
   logic [W-1:0]     b_pipe [N][N];
   logic             t_pipe [N][N];
   logic [ACC_W-1:0] acc    [N][N];

   assign take = in_valid && in_ready;

   function automatic logic [ACC_W-1:0] cell_op(
      input logic [1:0]       m,
      input logic [ACC_W-1:0] acc_v,
      input logic [W-1:0]     a,
      input logic [W-1:0]     b
   );
      logic [ACC_W-1:0] ae;
      logic [ACC_W-1:0] be;
      logic [ACC_W-1:0] ab;
      logic [ACC_W-1:0] prod;
      logic [ACC_W-1:0] s;
      logic [ACC_W:0]   sum;
      logic [ACC_W-1:0] r;
      ae   = ACC_W'(a);
      be   = ACC_W'(b);
      ab   = ACC_W'(a & b);
      prod = ae * be;
      sum  = {1'b0, acc_v} + {1'b0, prod};
      s    = ae + be;
      unique case (m)
         2'b00:   r = acc_v | ab;
         2'b01:   r = acc_v ^ ab;
         2'b10:   r = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
         default: r = (s > acc_v) ? s : acc_v;
      endcase
      return r;
   endfunction

   // Operand entering cell (i,j): skewed lane at the edge, neighbour reg inside.
   always_comb begin
      a_pipe[0][0] = in_a[W-1:0];
      t_pipe[0][0] = take;
      b_pipe[0][0] = in_b[W-1:0];
      for (int i = 1; i < N; i++) begin
         a_pipe[i][0] = a_dl[i][i-1];
         t_pipe[i][0] = v_dl[i-1];
         b_pipe[0][i] = b_dl[i][i-1];
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 1; j < N; j++) begin
            a_pipe[i][j] = a_reg[i][j-1];
            t_pipe[i][j] = t_reg[i][j-1];
         end
      end
      for (int i = 1; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            b_pipe[i][j] = b_reg[i-1][j];
         end
      end
   end

   always_comb begin
      row_sel  = (state == DRAIN) ? RW'(row + 1'b1) : '0;
      row_data = '0;
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            if (RW'(r) == row_sel) begin
               row_data[j*ACC_W +: ACC_W] = acc[r][j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int d = 0; d < N - 1; d++) begin
               a_dl[i][d]  <= '0;
               b_dl[i][d]  <= '0;
               a_reg[i][d] <= '0;
               t_reg[i][d] <= 1'b0;
               b_reg[d][i] <= '0;
            end
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= '0;
            end
         end
         for (int d = 0; d < N - 1; d++) begin
            v_dl[d] <= 1'b0;
         end
      end else begin
         v_dl[0] <= take;
         for (int d = 1; d < N - 1; d++) begin
            v_dl[d] <= v_dl[d-1];
         end
         for (int i = 0; i < N; i++) begin
            a_dl[i][0] <= in_a[i*W +: W];
            b_dl[i][0] <= in_b[i*W +: W];
            for (int d = 1; d < N - 1; d++) begin
               a_dl[i][d] <= a_dl[i][d-1];
               b_dl[i][d] <= b_dl[i][d-1];
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (j < N - 1) begin
                  a_reg[i][j] <= a_pipe[i][j];
                  t_reg[i][j] <= t_pipe[i][j];
               end
               if (i < N - 1) begin
                  b_reg[i][j] <= b_pipe[i][j];
               end
               if (state == CLEAR) begin
                  acc[i][j] <= '0;
               end else if (t_pipe[i][j]) begin
                  acc[i][j] <= cell_op(mode_q, acc[i][j],
                                       a_pipe[i][j], b_pipe[i][j]);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mode_q    <= 2'b00;
         flush_cnt <= '0;
         row       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  busy   <= 1'b1;
                  state  <= CLEAR;
               end
            end
            CLEAR: begin
               in_ready <= 1'b1;
               state    <= LOAD;
            end
            LOAD: begin
               if (take && in_last) begin
                  in_ready  <= 1'b0;
                  flush_cnt <= '0;
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               // Last bubble reaches the far corner on the final flush edge.
               if (flush_cnt == FW'(2 * N - 2)) begin
                  row       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= row_data;
                  out_last  <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (row == RW'(N - 1)) begin
                     row       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_data  <= '0;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     row      <= row + 1'b1;
                     out_data <= row_data;
                     out_last <= (row_sel == RW'(N - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
